mtrx_mul_sequencer: RTL and testbench

MTRX_MUL_SEQUENCER -- requirements
Module: mtrx_mul_sequencer

---
 rtl/mtrx_pkg.sv | 25 ++
 rtl/mtrx_mac.sv | 49 ++++
 rtl/mtrx_mul_sequencer.sv | 150 +++++++++++++++
 tb/tb_mtrx_mul_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtrx_pkg.sv
// Shared widths, state encoding and element indexing for the 5x5 matrix multiply sequencer.
package mtrx_pkg;

    localparam int unsigned N      = 5;
    localparam int unsigned ELEM_W = 8;
    localparam int unsigned MAT_W  = N * N * ELEM_W;
    localparam int unsigned ACC_W  = 19;
    localparam int unsigned PROD_W = 2 * ELEM_W;
    localparam int unsigned IDX_W  = 3;

    localparam logic MODE_MM = 1'b0;
    localparam logic MODE_MS = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // LSB position of element (r,col) in a row-major packed matrix
    function automatic int unsigned elem_lsb(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] col);
        return (32'(r) * N + 32'(col)) * ELEM_W;
    endfunction

endpackage

// File: rtl/mtrx_mac.sv
// 8x8 multiply-accumulate with element output stage; MTRX_SEQ_SAT_EN selects saturation
// instead of modulo-256 truncation of each element result.
module mtrx_mac
    import mtrx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              step,
    input  logic              flush,
    input  logic [ELEM_W-1:0] op_a,
    input  logic [ELEM_W-1:0] op_b,
    output logic [ELEM_W-1:0] elem_c
);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  sum;
    logic [PROD_W-1:0] prod;

    always_comb begin
        prod = PROD_W'(op_a) * PROD_W'(op_b);
        sum  = acc_q + ACC_W'(prod);
`ifdef MTRX_SEQ_SAT_EN
        elem_c = (sum > ACC_W'({ELEM_W{1'b1}})) ? {ELEM_W{1'b1}} : ELEM_W'(sum);
`else
        elem_c = ELEM_W'(sum);
`endif
    end

    // The final term of a dot product is consumed straight from sum, so acc restarts at zero
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (step) begin
            acc_d = flush ? '0 : sum;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mtrx_mul_sequencer.sv
// Sequencer for 5x5 matrix-matrix (125 MAC cycles) and matrix-scalar (25 cycles) products.
// Element results saturate when MTRX_SEQ_SAT_EN is defined, otherwise wrap modulo 256.
module mtrx_mul_sequencer
    import mtrx_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ELEM_W-1:0] scalar,
    input  logic [MAT_W-1:0]  a,
    input  logic [MAT_W-1:0]  b,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [MAT_W-1:0]  c
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  row_q, row_d, col_q, col_d, k_q, k_d;
    logic [MAT_W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
    logic [ELEM_W-1:0] scalar_q, scalar_d;
    logic              mode_q, mode_d;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic              accept_c, run_c, flush_c, last_c;
    logic [ELEM_W-1:0] op_a_c, op_b_c, elem_c;

    always_comb begin
        accept_c = (state_q == ST_IDLE) && start;
        run_c    = (state_q == ST_RUN);
        flush_c  = (mode_q == MODE_MS) || (k_q == IDX_W'(N - 1));
        last_c   = flush_c && (row_q == IDX_W'(N - 1)) && (col_q == IDX_W'(N - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered from the upcoming state so they track state_q exactly
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        op_a_c = a_q[elem_lsb(row_q, (mode_q == MODE_MS) ? col_q : k_q) +: ELEM_W];
        op_b_c = (mode_q == MODE_MS) ? scalar_q : b_q[elem_lsb(k_q, col_q) +: ELEM_W];
    end

    mtrx_mac u_mac (
        .clock  (clock),
        .reset  (reset),
        .clr    (accept_c),
        .step   (run_c),
        .flush  (flush_c),
        .op_a   (op_a_c),
        .op_b   (op_b_c),
        .elem_c (elem_c)
    );

    // Operand latch, row-major element walk and result write-back
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        scalar_d = scalar_q;
        mode_d   = mode_q;
        row_d    = row_q;
        col_d    = col_q;
        k_d      = k_q;
        c_d      = c_q;
        if (accept_c) begin
            a_d      = a;
            b_d      = b;
            scalar_d = scalar;
            mode_d   = mode;
            row_d    = '0;
            col_d    = '0;
            k_d      = '0;
            c_d      = '0;
        end else if (run_c) begin
            if (flush_c) begin
                c_d[elem_lsb(row_q, col_q) +: ELEM_W] = elem_c;
                k_d = '0;
                if (col_q == IDX_W'(N - 1)) begin
                    col_d = '0;
                    row_d = row_q + IDX_W'(1);
                end else begin
                    col_d = col_q + IDX_W'(1);
                end
            end else begin
                k_d = k_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            scalar_q <= '0;
            mode_q   <= MODE_MM;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            c_q      <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            scalar_q <= scalar_d;
            mode_q   <= mode_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            c_q      <= c_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign c     = c_q;

endmodule

// File: tb/tb_mtrx_mul_sequencer.sv
// Self-checking bench: command-level reference model plus directed literal checks.
module tb_mtrx_mul_sequencer;

    localparam int MW = 200;

    logic          clock;
    logic          reset;
    logic          start;
    logic          mode;
    logic [7:0]    scalar;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          ready;
    logic          busy;
    logic          done;
    logic [MW-1:0] c;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 0;

    mtrx_mul_sequencer dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .scalar (scalar),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .c      (c)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int el(input logic [MW-1:0] m, input int r, input int cc);
        return int'(m[(r*5+cc)*8 +: 8]);
    endfunction

    function automatic logic [MW-1:0] fill(input int v);
        logic [MW-1:0] m;
        for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(v);
        return m;
    endfunction

    // Rows alternate {1,2,1,2,1} / {2,1,2,1,2}, each element scaled by s
    function automatic logic [MW-1:0] pat(input int s);
        logic [MW-1:0] m;
        for (int r = 0; r < 5; r++)
            for (int cc = 0; cc < 5; cc++)
                m[(r*5+cc)*8 +: 8] = 8'((((r + cc) % 2) != 0) ? 2 * s : s);
        return m;
    endfunction

    function automatic logic [MW-1:0] rows(input int ev, input int od);
        logic [MW-1:0] m;
        for (int r = 0; r < 5; r++)
            for (int cc = 0; cc < 5; cc++)
                m[(r*5+cc)*8 +: 8] = 8'(((r % 2) != 0) ? od : ev);
        return m;
    endfunction

    function automatic logic [MW-1:0] ref_res(input logic md, input logic [7:0] s,
                                              input logic [MW-1:0] aa, input logic [MW-1:0] bb);
        logic [MW-1:0] m;
        int sum;
        for (int r = 0; r < 5; r++)
            for (int cc = 0; cc < 5; cc++) begin
                sum = 0;
                if (md) sum = el(aa, r, cc) * int'(s);
                else for (int k = 0; k < 5; k++) sum += el(aa, r, k) * el(bb, k, cc);
`ifdef MTRX_SEQ_SAT_EN
                if (sum > 255) sum = 255;
`endif
                m[(r*5+cc)*8 +: 8] = 8'(sum % 256);
            end
        return m;
    endfunction

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0b want=%0b t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkm(input string nm, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Command-level model: a command occupies a fixed number of run cycles, then one done cycle
    bit            m_ready = 1;
    bit            m_done  = 0;
    int            m_left  = 0;
    logic [MW-1:0] m_c     = '0;
    logic [MW-1:0] m_pend  = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_ready = 1; m_done = 0; m_left = 0; m_c = '0;
        end else if (m_ready && start) begin
            m_ready = 0;
            m_left  = mode ? 25 : 125;
            m_pend  = ref_res(mode, scalar, a, b);
            m_c     = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_c    = m_pend;
            end
        end else if (m_done) begin
            m_done  = 0;
            m_ready = 1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk1("ready", ready, m_ready);
            chk1("busy", busy, m_left > 0);
            chk1("done", done, m_done);
            if (m_left == 0) chkm("c_model", c, m_c);
        end
    end

    // Pulses start for one cycle (already raised by caller) and counts edges until done
    task automatic run_cmd(input int max, output int lat);
        lat = 0;
        do begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start = 1'b0;
        end while (!done && lat < max);
    endtask

    int lat;
    int dones;
    int last_i;
    int npulse;
    bit prev_done;
    int wt;

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; scalar = 8'd0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_en = 1;
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chkm("rst_c", c, '0);
        reset = 1'b0;
        @(negedge clock);

        // Mode 0 pattern: each row sums to 7 or 8
        a = pat(1); b = fill(1); mode = 1'b0; start = 1'b1;
        run_cmd(200, lat);
        chki("mm_latency", lat, 126);
        chkm("mm_result", c, rows(7, 8));
        @(negedge clock);
        chk1("mm_done_one_cycle", done, 1'b0);
        chk1("mm_ready_after", ready, 1'b1);
        chkm("mm_hold", c, rows(7, 8));

        // Mode 1 scalar 2
        a = pat(1); mode = 1'b1; scalar = 8'd2; start = 1'b1;
        run_cmd(100, lat);
        chki("ms_latency", lat, 26);
        chkm("ms_result", c, pat(2));
        @(negedge clock);

        // Overflow: true element value 1280
        a = fill(16); b = fill(16); mode = 1'b0; start = 1'b1;
        run_cmd(200, lat);
        chki("ovf_latency", lat, 126);
`ifdef MTRX_SEQ_SAT_EN
        chkm("ovf_result", c, fill(255));
`else
        chkm("ovf_result", c, fill(0));
`endif
        @(negedge clock);

        // Busy-ignore: late starts and mid-run operand changes must not matter
        a = pat(1); b = fill(1); mode = 1'b0; dones = 0;
        for (int i = 0; i < 200; i++) begin
            start = (i == 0 || i == 10 || i == 60);
            if (i == 1) begin
                a = fill(3); b = fill(2); mode = 1'b1; scalar = 8'd9;
            end
            if (i > 0 && done) dones++;
            @(negedge clock);
        end
        start = 1'b0;
        chki("ign_done_count", dones, 1);
        chkm("ign_result", c, rows(7, 8));

        // Reset abort during a mode-0 run
        a = pat(1); b = fill(1); mode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (50) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chkm("abort_c", c, '0);
        chk1("abort_ready", ready, 1'b1);
        chk1("abort_done", done, 1'b0);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        chki("abort_no_done", dones, 0);
        a = pat(1); mode = 1'b1; scalar = 8'd3; start = 1'b1;
        run_cmd(100, lat);
        chki("abort_new_latency", lat, 26);
        chkm("abort_new_result", c, pat(3));
        @(negedge clock);

        // Back-to-back with start held high
        a = fill(7); mode = 1'b1; scalar = 8'd5; start = 1'b1;
        last_i = -1; npulse = 0; prev_done = 0;
        for (int i = 0; i < 120; i++) begin
            if (prev_done) chk1("b2b_ready_gap", ready, 1'b1);
            if (done) begin
                if (last_i >= 0) chki("b2b_spacing", i - last_i, 27);
                last_i = i;
                npulse++;
            end
            prev_done = done;
            @(negedge clock);
        end
        chki("b2b_pulses", npulse, 4);
        start = 1'b0;
        wt = 0;
        while (!ready && wt < 200) begin
            @(negedge clock);
            wt++;
        end
        chk1("b2b_drain", ready, 1'b1);
        @(negedge clock);

        // Randomized traffic with occasional resets, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            for (int j = 0; j < 25; j++) begin
                a[j*8 +: 8] = 8'($urandom);
                b[j*8 +: 8] = 8'($urandom);
            end
            scalar = 8'($urandom);
            mode   = ($urandom_range(0, 2) != 0);
            start  = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            @(negedge clock);
        end
        start = 1'b0; reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
